// File: rtl/melody_pkg.sv
// Shared types and default tune tables for the melody sequencer.
// Tables are stored at the default note width and resized in the ROM.
package melody_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_PLAY,
      S_GAP,
      S_DONE
   } state_t;

   localparam logic [6:0] NOTE_REST = 7'd0;
   localparam logic [6:0] NOTE_END  = '1;

   localparam int WIN_LEN  = 8;
   localparam int LOSE_LEN = 4;

   localparam logic [6:0] WIN_NOTES [8] = '{
      7'd8, 7'd10, 7'd8, 7'd12, 7'd8, 7'd9, 7'd10, 7'd12
   };
   localparam logic [3:0] WIN_DURS [8] = '{
      4'd2, 4'd2, 4'd4, 4'd4, 4'd2, 4'd2, 4'd4, 4'd8
   };

   localparam logic [6:0] LOSE_NOTES [4] = '{
      7'd12, 7'd10, 7'd9, 7'd8
   };
   localparam logic [3:0] LOSE_DURS [4] = '{
      4'd4, 4'd4, 4'd4, 4'd8
   };

endpackage

// File: rtl/melody_rom.sv
// Combinational tune ROM: (tune, idx) -> note code and duration.
// Any slot past the end of a tune, and every unused tune, reads as END.
import melody_pkg::*;

module melody_rom #(
   parameter int NOTE_W = 7,
   parameter int DUR_W  = 4,
   parameter int TSEL_W = 2,
   parameter int IDX_W  = 4
) (
   input  logic [TSEL_W-1:0] tune,
   input  logic [IDX_W-1:0]  idx,
   output logic [NOTE_W-1:0] note,
   output logic [DUR_W-1:0]  dur
);

   logic [2:0] i3;

   assign i3 = 3'(idx);

   // table lookup, END with zero duration by default
   always_comb begin
      note = '1;
      dur  = '0;
      if (tune == TSEL_W'(0) && int'(idx) < WIN_LEN) begin
         note = NOTE_W'(WIN_NOTES[i3]);
         dur  = DUR_W'(WIN_DURS[i3]);
      end else if (tune == TSEL_W'(1) && int'(idx) < LOSE_LEN) begin
         note = NOTE_W'(LOSE_NOTES[i3[1:0]]);
         dur  = DUR_W'(LOSE_DURS[i3[1:0]]);
      end
   end

endmodule

// File: rtl/melody_player.sv
// Tune sequencer: walks a ROM tune note by note, handing each note
// to the external tone counter and waiting for its note_done pulse.
import melody_pkg::*;

module melody_player #(
   parameter int NOTE_W     = 7,
   parameter int DUR_W      = 4,
   parameter int MAX_NOTES  = 16,
   parameter int NUM_TUNES  = 4,
   parameter int GAP_CYCLES = 1,
   localparam int TSEL_W =
      (NUM_TUNES > 1) ? $clog2(NUM_TUNES) : 1,
   localparam int IDX_W =
      (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [TSEL_W-1:0] tune_sel,
   input  logic              loop,
   input  logic              abort,
   input  logic              note_done,
   output logic              tone_en,
   output logic [NOTE_W-1:0] tone_code,
   output logic [DUR_W-1:0]  tone_dur,
   output logic [IDX_W-1:0]  note_idx,
   output logic              busy,
   output logic              done
);

   localparam int GAP_W =
      (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST =
      GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [IDX_W:0] LAST_IDX =
      (IDX_W + 1)'(MAX_NOTES - 1);
   localparam logic [NOTE_W-1:0] END_CODE = '1;

   state_t              state_q, state_d;
   logic [IDX_W:0]      idx_q, idx_d;
   logic [TSEL_W-1:0]   tune_q, tune_d;
   logic [GAP_W-1:0]    gap_q, gap_d;
   logic [NOTE_W-1:0]   note_q, note_d;
   logic [DUR_W-1:0]    dur_q, dur_d;
   logic [NOTE_W-1:0]   rom_note;
   logic [DUR_W-1:0]    rom_dur;
   logic                past_end;

   melody_rom #(
      .NOTE_W (NOTE_W),
      .DUR_W  (DUR_W),
      .TSEL_W (TSEL_W),
      .IDX_W  (IDX_W)
   ) u_rom (
      .tune (tune_q),
      .idx  (idx_q[IDX_W-1:0]),
      .note (rom_note),
      .dur  (rom_dur)
   );

   // idx carries one extra bit so running off the ROM is visible
   assign past_end = idx_q > LAST_IDX;

   // next-state, counters and note register
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      tune_d  = tune_q;
      gap_d   = gap_q;
      note_d  = note_q;
      dur_d   = dur_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               tune_d  = tune_sel;
               idx_d   = '0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (abort) begin
               state_d = S_DONE;
            end else if (rom_note == END_CODE || past_end) begin
               // an empty tune must not spin forever in loop mode
               if (loop && idx_q != '0) begin
                  idx_d = '0;
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               note_d  = rom_note;
               dur_d   = rom_dur;
               state_d = S_PLAY;
            end
         end
         S_PLAY: begin
            if (abort) begin
               state_d = S_DONE;
            end else if (note_done) begin
               idx_d   = idx_q + (IDX_W + 1)'(1);
               gap_d   = '0;
               state_d = (GAP_CYCLES > 0) ? S_GAP : S_LOAD;
            end
         end
         S_GAP: begin
            if (abort) begin
               state_d = S_DONE;
            end else if (gap_q == GAP_LAST) begin
               state_d = S_LOAD;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         S_DONE: begin
            if (!start) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         tune_q  <= '0;
         gap_q   <= '0;
         note_q  <= '0;
         dur_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         tune_q  <= tune_d;
         gap_q   <= gap_d;
         note_q  <= note_d;
         dur_q   <= dur_d;
      end
   end

   assign tone_en   = state_q == S_PLAY;
   assign tone_code = tone_en ? note_q : '0;
   assign tone_dur  = tone_en ? dur_q : '0;
   assign note_idx  = idx_q[IDX_W-1:0];
   assign busy      = state_q == S_LOAD ||
                      state_q == S_PLAY ||
                      state_q == S_GAP;
   assign done      = state_q == S_DONE;

endmodule

// File: tb/tb_melody_player.sv
// Directed bench for melody_player: default build plus a
// zero-gap build driven separately.
`timescale 1ns/1ps
module tb_melody_player;

   logic       clk = 1'b0;
   logic       reset;
   logic       start, loop, abort, note_done;
   logic [1:0] tune_sel;
   logic       tone_en, busy, done;
   logic [6:0] tone_code;
   logic [3:0] tone_dur, note_idx;

   logic       start0, note_done0;
   logic [1:0] tune_sel0;
   logic       tone_en0, busy0, done0;
   logic [6:0] tone_code0;
   logic [3:0] tone_dur0, note_idx0;

   int checks = 0;
   int failures = 0;

   int win_c [8] = '{8, 10, 8, 12, 8, 9, 10, 12};
   int win_d [8] = '{2, 2, 4, 4, 2, 2, 4, 8};
   int lose_c [4] = '{12, 10, 9, 8};
   int lose_d [4] = '{4, 4, 4, 8};

   always #5 clk = ~clk;

   melody_player dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .tune_sel  (tune_sel),
      .loop      (loop),
      .abort     (abort),
      .note_done (note_done),
      .tone_en   (tone_en),
      .tone_code (tone_code),
      .tone_dur  (tone_dur),
      .note_idx  (note_idx),
      .busy      (busy),
      .done      (done)
   );

   melody_player #(.GAP_CYCLES(0)) dut0 (
      .clk       (clk),
      .reset     (reset),
      .start     (start0),
      .tune_sel  (tune_sel0),
      .loop      (1'b0),
      .abort     (1'b0),
      .note_done (note_done0),
      .tone_en   (tone_en0),
      .tone_code (tone_code0),
      .tone_dur  (tone_dur0),
      .note_idx  (note_idx0),
      .busy      (busy0),
      .done      (done0)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_done();
      tick();
      tick();
      note_done = 1'b1;
      tick();
      note_done = 1'b0;
   endtask

   task automatic wait_tone(output int n);
      n = -1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (tone_en) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic wait_done(output int n);
      n = -1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (done) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({tone_en, tone_code, tone_dur, note_idx, busy, done} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got en=%b code=%0d dur=%0d idx=%0d busy=%b done=%b exp all 0",
                  tone_en, tone_code, tone_dur, note_idx, busy, done);
      end
      @(negedge clk);
      reset = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL idle_after_reset got busy=%b done=%b exp 0 0", busy, done);
      end
   endtask

   task automatic test_win();
      int n;
      tune_sel = 2'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || tone_en !== 1'b0) begin
         failures++;
         $display("FAIL load_state got busy=%b en=%b exp 1 0", busy, tone_en);
      end
      tick();
      checks++;
      if (tone_en !== 1'b1) begin
         failures++;
         $display("FAIL start_latency got en=%b exp 1", tone_en);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (tone_code !== 7'(win_c[i]) || tone_dur !== 4'(win_d[i]) ||
             note_idx !== 4'(i)) begin
            failures++;
            $display("FAIL win_note%0d got code=%0d dur=%0d idx=%0d exp %0d %0d %0d",
                     i, tone_code, tone_dur, note_idx, win_c[i], win_d[i], i);
         end
         if (i == 7) start = 1'b1;
         pulse_done();
         checks++;
         if (tone_en !== 1'b0 || tone_code !== 7'd0 || tone_dur !== 4'd0) begin
            failures++;
            $display("FAIL win_gap%0d got en=%b code=%0d dur=%0d exp 0 0 0",
                     i, tone_en, tone_code, tone_dur);
         end
         if (i < 7) begin
            wait_tone(n);
            checks++;
            if (n !== 2) begin
               failures++;
               $display("FAIL win_silent%0d got %0d exp 2", i, n);
            end
         end else begin
            wait_done(n);
            checks++;
            if (n !== 2 || busy !== 1'b0) begin
               failures++;
               $display("FAIL win_finish got n=%0d busy=%b exp 2 0", n, busy);
            end
         end
      end
   endtask

   task automatic test_done_hold();
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (done !== 1'b1) begin
            failures++;
            $display("FAIL done_hold%0d got %b exp 1", k, done);
         end
      end
      start = 1'b0;
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL done_release got done=%b busy=%b exp 0 0", done, busy);
      end
   endtask

   task automatic test_loop();
      int n;
      tune_sel = 2'd1;
      loop = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      checks++;
      if (tone_en !== 1'b1) begin
         failures++;
         $display("FAIL loop_first got en=%b exp 1", tone_en);
      end
      for (int p = 0; p < 2; p++) begin
         for (int j = 0; j < 4; j++) begin
            checks++;
            if (tone_code !== 7'(lose_c[j]) || tone_dur !== 4'(lose_d[j]) ||
                note_idx !== 4'(j)) begin
               failures++;
               $display("FAIL loop_p%0d_n%0d got code=%0d dur=%0d idx=%0d exp %0d %0d %0d",
                        p, j, tone_code, tone_dur, note_idx, lose_c[j], lose_d[j], j);
            end
            if (p == 1 && j == 1) loop = 1'b0;
            pulse_done();
            if (j < 3) begin
               wait_tone(n);
               checks++;
               if (n !== 2) begin
                  failures++;
                  $display("FAIL loop_silent_p%0d_n%0d got %0d exp 2", p, j, n);
               end
            end else if (p == 0) begin
               wait_tone(n);
               checks++;
               if (n !== 3) begin
                  failures++;
                  $display("FAIL loop_wrap got %0d exp 3", n);
               end
            end else begin
               wait_done(n);
               checks++;
               if (n !== 2) begin
                  failures++;
                  $display("FAIL loop_exit got %0d exp 2", n);
               end
            end
         end
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL loop_idle got done=%b exp 0", done);
      end
   endtask

   task automatic test_abort();
      int n;
      tune_sel = 2'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      for (int i = 0; i < 2; i++) begin
         pulse_done();
         wait_tone(n);
      end
      checks++;
      if (note_idx !== 4'd2 || tone_code !== 7'd8 || tone_en !== 1'b1) begin
         failures++;
         $display("FAIL abort_setup got idx=%0d code=%0d en=%b exp 2 8 1",
                  note_idx, tone_code, tone_en);
      end
      tick();
      abort = 1'b1;
      note_done = 1'b1;
      tick();
      abort = 1'b0;
      note_done = 1'b0;
      checks++;
      if (done !== 1'b1 || tone_en !== 1'b0 || note_idx !== 4'd2 ||
          busy !== 1'b0) begin
         failures++;
         $display("FAIL abort got done=%b en=%b idx=%0d busy=%b exp 1 0 2 0",
                  done, tone_en, note_idx, busy);
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL abort_idle got done=%b exp 0", done);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      tune_sel = 2'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      pulse_done();
      wait_tone(n);
      checks++;
      if (note_idx !== 4'd1 || tone_code !== 7'd10) begin
         failures++;
         $display("FAIL rst_setup got idx=%0d code=%0d exp 1 10", note_idx, tone_code);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({tone_en, tone_code, tone_dur, note_idx, busy, done} !== '0) begin
         failures++;
         $display("FAIL rst_async got en=%b code=%0d dur=%0d idx=%0d busy=%b done=%b exp all 0",
                  tone_en, tone_code, tone_dur, note_idx, busy, done);
      end
      @(negedge clk);
      reset = 1'b0;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      checks++;
      if (tone_en !== 1'b1 || tone_code !== 7'd8 || note_idx !== 4'd0) begin
         failures++;
         $display("FAIL rst_replay got en=%b code=%0d idx=%0d exp 1 8 0",
                  tone_en, tone_code, note_idx);
      end
      pulse_done();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tick();
   endtask

   task automatic test_no_gap();
      tune_sel0 = 2'd0;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      tick();
      checks++;
      if (tone_en0 !== 1'b1) begin
         failures++;
         $display("FAIL nogap_first got en=%b exp 1", tone_en0);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (tone_code0 !== 7'(win_c[i]) || tone_dur0 !== 4'(win_d[i]) ||
             note_idx0 !== 4'(i)) begin
            failures++;
            $display("FAIL nogap_note%0d got code=%0d dur=%0d idx=%0d exp %0d %0d %0d",
                     i, tone_code0, tone_dur0, note_idx0, win_c[i], win_d[i], i);
         end
         tick();
         tick();
         note_done0 = 1'b1;
         tick();
         checks++;
         if (tone_en0 !== 1'b0 || busy0 !== 1'b1) begin
            failures++;
            $display("FAIL nogap_load%0d got en=%b busy=%b exp 0 1", i, tone_en0, busy0);
         end
         tick();
         note_done0 = 1'b0;
         if (i < 7) begin
            checks++;
            if (tone_en0 !== 1'b1 || note_idx0 !== 4'(i + 1)) begin
               failures++;
               $display("FAIL nogap_next%0d got en=%b idx=%0d exp 1 %0d",
                        i, tone_en0, note_idx0, i + 1);
            end
         end else begin
            checks++;
            if (done0 !== 1'b1) begin
               failures++;
               $display("FAIL nogap_done got %b exp 1", done0);
            end
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      loop = 1'b0;
      abort = 1'b0;
      note_done = 1'b0;
      tune_sel = 2'd0;
      start0 = 1'b0;
      note_done0 = 1'b0;
      tune_sel0 = 2'd0;
      test_reset();
      test_win();
      test_done_hold();
      test_loop();
      test_abort();
      test_reset_mid();
      test_no_gap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
